// File: rtl/itrx_aib_phy_bscan_mch_if.sv
// TAP-side and AIB-channel-side signal bundle for the multi-channel bscan controller.
// The TAP/bench drives through master; the controller uses slave. Flow is per-tck, no backpressure.
interface itrx_aib_phy_bscan_mch_if #(
  parameter int NUM_CH = 4,
  parameter int IR_WID = 7
);
  logic [IR_WID-1:0] ir_latched;
  logic              ir_update;
  logic              capture_dr;
  logic              shift_dr;
  logic              update_dr;
  logic              tdi;
  logic              chsel_tdo;
  logic              chsel_active;
  logic [NUM_CH-1:0] ch_mask;
  logic [NUM_CH-1:0] jtag_scan_en;
  logic [NUM_CH-1:0] jtag_rstn_en;
  logic [NUM_CH-1:0] jtag_rstn;
  logic [NUM_CH-1:0] jtag_mode;
  logic [NUM_CH-1:0] jtag_clksel;
  logic [NUM_CH-1:0] jtag_weakpu;
  logic [NUM_CH-1:0] jtag_weakpdn;
  logic [NUM_CH-1:0] jtag_intest;

  modport master (
    output ir_latched, ir_update, capture_dr, shift_dr, update_dr, tdi,
    input  chsel_tdo, chsel_active, ch_mask,
    input  jtag_scan_en, jtag_rstn_en, jtag_rstn, jtag_mode,
    input  jtag_clksel, jtag_weakpu, jtag_weakpdn, jtag_intest
  );

  modport slave (
    input  ir_latched, ir_update, capture_dr, shift_dr, update_dr, tdi,
    output chsel_tdo, chsel_active, ch_mask,
    output jtag_scan_en, jtag_rstn_en, jtag_rstn, jtag_mode,
    output jtag_clksel, jtag_weakpu, jtag_weakpdn, jtag_intest
  );
endinterface

// File: rtl/itrx_aib_phy_bscan_mch.sv
// Multi-channel AIB private-instruction decoder with a JTAG-loadable channel-select mask.
// Outputs register on the tck edge sampling ir_update (1-cycle latency); no backpressure.
module itrx_aib_phy_bscan_mch #(
  parameter int         NUM_CH         = 4,
  parameter int         IR_WID         = 7,
  parameter logic [6:0] OPC_CHSEL      = 7'b100_1010,
  parameter logic [6:0] OPC_CLKSEL_CLR = 7'b001_1001
) (
  input logic                      tck,
  input logic                      reset_n,
  itrx_aib_phy_bscan_mch_if.slave  bus
);

  localparam logic [IR_WID-1:0] OP_SHIFT_EN     = IR_WID'(7'h0C);
  localparam logic [IR_WID-1:0] OP_SHIFT_DIS    = IR_WID'(7'h0D);
  localparam logic [IR_WID-1:0] OP_TRANSMIT_EN  = IR_WID'(7'h0E);
  localparam logic [IR_WID-1:0] OP_TRANSMIT_DIS = IR_WID'(7'h0F);
  localparam logic [IR_WID-1:0] OP_RESET_EN     = IR_WID'(7'h10);
  localparam logic [IR_WID-1:0] OP_RESET_DIS    = IR_WID'(7'h11);
  localparam logic [IR_WID-1:0] OP_WEAKPU_EN    = IR_WID'(7'h12);
  localparam logic [IR_WID-1:0] OP_WEAKPU_DIS   = IR_WID'(7'h13);
  localparam logic [IR_WID-1:0] OP_WEAKPDN_EN   = IR_WID'(7'h14);
  localparam logic [IR_WID-1:0] OP_WEAKPDN_DIS  = IR_WID'(7'h15);
  localparam logic [IR_WID-1:0] OP_INTEST_EN    = IR_WID'(7'h16);
  localparam logic [IR_WID-1:0] OP_INTEST_DIS   = IR_WID'(7'h17);
  localparam logic [IR_WID-1:0] OP_CLKSEL_SET   = IR_WID'(7'h18);
  localparam logic [IR_WID-1:0] OP_RST_OVRD_EN  = IR_WID'(7'h48);
  localparam logic [IR_WID-1:0] OP_RST_OVRD_DIS = IR_WID'(7'h49);
  localparam logic [IR_WID-1:0] OP_CLKSEL_CLR   = IR_WID'(OPC_CLKSEL_CLR);
  localparam logic [IR_WID-1:0] OP_CHSEL        = IR_WID'(OPC_CHSEL);

  logic [NUM_CH-1:0] shift_q,   shift_d;
  logic [NUM_CH-1:0] mask_q,    mask_d;
  logic [NUM_CH-1:0] scan_q,    scan_d;
  logic [NUM_CH-1:0] rstn_en_q, rstn_en_d;
  logic [NUM_CH-1:0] rstn_q,    rstn_d;
  logic [NUM_CH-1:0] mode_q,    mode_d;
  logic [NUM_CH-1:0] clksel_q,  clksel_d;
  logic [NUM_CH-1:0] weakpu_q,  weakpu_d;
  logic [NUM_CH-1:0] weakpdn_q, weakpdn_d;
  logic [NUM_CH-1:0] intest_q,  intest_d;
  logic              chsel_sel;

  assign chsel_sel = (bus.ir_latched == OP_CHSEL);

  always_comb begin
    shift_d   = shift_q;
    mask_d    = mask_q;
    scan_d    = scan_q;
    rstn_en_d = rstn_en_q;
    rstn_d    = rstn_q;
    mode_d    = mode_q;
    clksel_d  = clksel_q;
    weakpu_d  = weakpu_q;
    weakpdn_d = weakpdn_q;
    intest_d  = intest_q;

    if (chsel_sel) begin
      if (bus.capture_dr) begin
        shift_d = mask_q;
      end else if (bus.shift_dr) begin
        shift_d = (shift_q >> 1) | (NUM_CH'(bus.tdi) << (NUM_CH - 1));
      end
      if (bus.update_dr) begin
        mask_d = shift_q;
      end
    end

    // mask_q (not mask_d) so a same-edge mask update never affects this instruction
    if (bus.ir_update) begin
      case (bus.ir_latched)
        OP_SHIFT_EN:     scan_d    = scan_q    |  mask_q;
        OP_SHIFT_DIS:    scan_d    = scan_q    & ~mask_q;
        OP_TRANSMIT_EN:  mode_d    = mode_q    |  mask_q;
        OP_TRANSMIT_DIS: mode_d    = mode_q    & ~mask_q;
        OP_RESET_EN:     rstn_d    = rstn_q    & ~mask_q;
        OP_RESET_DIS:    rstn_d    = rstn_q    |  mask_q;
        OP_WEAKPU_EN:    weakpu_d  = weakpu_q  |  mask_q;
        OP_WEAKPU_DIS:   weakpu_d  = weakpu_q  & ~mask_q;
        OP_WEAKPDN_EN:   weakpdn_d = weakpdn_q |  mask_q;
        OP_WEAKPDN_DIS:  weakpdn_d = weakpdn_q & ~mask_q;
        OP_INTEST_EN:    intest_d  = intest_q  |  mask_q;
        OP_INTEST_DIS:   intest_d  = intest_q  & ~mask_q;
        OP_CLKSEL_SET:   clksel_d  = clksel_q  |  mask_q;
        OP_CLKSEL_CLR:   clksel_d  = clksel_q  & ~mask_q;
        OP_RST_OVRD_EN:  rstn_en_d = rstn_en_q |  mask_q;
        OP_RST_OVRD_DIS: rstn_en_d = rstn_en_q & ~mask_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      shift_q   <= '0;
      mask_q    <= '1;
      scan_q    <= '0;
      rstn_en_q <= '0;
      rstn_q    <= '1;
      mode_q    <= '0;
      clksel_q  <= '0;
      weakpu_q  <= '0;
      weakpdn_q <= '0;
      intest_q  <= '0;
    end else begin
      shift_q   <= shift_d;
      mask_q    <= mask_d;
      scan_q    <= scan_d;
      rstn_en_q <= rstn_en_d;
      rstn_q    <= rstn_d;
      mode_q    <= mode_d;
      clksel_q  <= clksel_d;
      weakpu_q  <= weakpu_d;
      weakpdn_q <= weakpdn_d;
      intest_q  <= intest_d;
    end
  end

  assign bus.chsel_tdo    = shift_q[0];
  assign bus.chsel_active = chsel_sel;
  assign bus.ch_mask      = mask_q;
  assign bus.jtag_scan_en = scan_q;
  assign bus.jtag_rstn_en = rstn_en_q;
  assign bus.jtag_rstn    = rstn_q;
  assign bus.jtag_mode    = mode_q;
  assign bus.jtag_clksel  = clksel_q;
  assign bus.jtag_weakpu  = weakpu_q;
  assign bus.jtag_weakpdn = weakpdn_q;
  assign bus.jtag_intest  = intest_q;

endmodule

// File: tb/tb_itrx_aib_phy_bscan_mch.sv
// Directed bench for the multi-channel bscan controller; a reference model pushes
// expected values to a scoreboard queue that is popped as DUT outputs are sampled.
module tb_itrx_aib_phy_bscan_mch;

  localparam logic [6:0] OPC_CHSEL = 7'h4A;
  localparam logic [6:0] OPC_CLR   = 7'h19;

  logic tck;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] exp_q[$];

  logic [3:0] m_mask, m_scan, m_rstn_en, m_rstn, m_mode, m_clk, m_pu, m_pdn, m_int;

  itrx_aib_phy_bscan_mch_if #(.NUM_CH(4), .IR_WID(7)) bus ();

  itrx_aib_phy_bscan_mch #(
    .NUM_CH(4), .IR_WID(7), .OPC_CHSEL(OPC_CHSEL), .OPC_CLKSEL_CLR(OPC_CLR)
  ) dut (
    .tck(tck), .reset_n(reset_n), .bus(bus.slave)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  task automatic tick;
    @(posedge tck);
    @(negedge tck);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, observed=%0h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  task automatic model_reset;
    m_mask = 4'hF; m_scan = 4'h0; m_rstn_en = 4'h0; m_rstn = 4'hF;
    m_mode = 4'h0; m_clk  = 4'h0; m_pu      = 4'h0; m_pdn  = 4'h0; m_int = 4'h0;
  endtask

  task automatic model_ir(input logic [6:0] op);
    case (op)
      7'h0C: m_scan    = m_scan    |  m_mask;
      7'h0D: m_scan    = m_scan    & ~m_mask;
      7'h0E: m_mode    = m_mode    |  m_mask;
      7'h0F: m_mode    = m_mode    & ~m_mask;
      7'h10: m_rstn    = m_rstn    & ~m_mask;
      7'h11: m_rstn    = m_rstn    |  m_mask;
      7'h12: m_pu      = m_pu      |  m_mask;
      7'h13: m_pu      = m_pu      & ~m_mask;
      7'h14: m_pdn     = m_pdn     |  m_mask;
      7'h15: m_pdn     = m_pdn     & ~m_mask;
      7'h16: m_int     = m_int     |  m_mask;
      7'h17: m_int     = m_int     & ~m_mask;
      7'h18: m_clk     = m_clk     |  m_mask;
      7'h19: m_clk     = m_clk     & ~m_mask;
      7'h48: m_rstn_en = m_rstn_en |  m_mask;
      7'h49: m_rstn_en = m_rstn_en & ~m_mask;
      default: ;
    endcase
  endtask

  task automatic push_all;
    exp_q.push_back(32'(m_mask));  exp_q.push_back(32'(m_scan));
    exp_q.push_back(32'(m_rstn_en)); exp_q.push_back(32'(m_rstn));
    exp_q.push_back(32'(m_mode));  exp_q.push_back(32'(m_clk));
    exp_q.push_back(32'(m_pu));    exp_q.push_back(32'(m_pdn));
    exp_q.push_back(32'(m_int));
  endtask

  task automatic check_all(input string t);
    chk({t, ".ch_mask"},  32'(bus.ch_mask));
    chk({t, ".scan_en"},  32'(bus.jtag_scan_en));
    chk({t, ".rstn_en"},  32'(bus.jtag_rstn_en));
    chk({t, ".rstn"},     32'(bus.jtag_rstn));
    chk({t, ".mode"},     32'(bus.jtag_mode));
    chk({t, ".clksel"},   32'(bus.jtag_clksel));
    chk({t, ".weakpu"},   32'(bus.jtag_weakpu));
    chk({t, ".weakpdn"},  32'(bus.jtag_weakpdn));
    chk({t, ".intest"},   32'(bus.jtag_intest));
  endtask

  task automatic do_ir(input string t, input logic [6:0] op);
    model_ir(op);
    bus.ir_latched = op;
    bus.ir_update  = 1'b1;
    push_all();
    tick();
    bus.ir_update  = 1'b0;
    check_all(t);
  endtask

  task automatic chsel_write(input logic [3:0] val);
    bus.ir_latched = OPC_CHSEL;
    bus.capture_dr = 1'b1;
    tick();
    bus.capture_dr = 1'b0;
    bus.shift_dr   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.tdi = val[i];
      tick();
    end
    bus.shift_dr  = 1'b0;
    bus.update_dr = 1'b1;
    m_mask = val;
    tick();
    bus.update_dr = 1'b0;
    exp_q.push_back(32'(val));
    chk("chsel_write.mask", 32'(bus.ch_mask));
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.ir_latched = 7'h00;
    bus.ir_update  = 1'b0;
    bus.capture_dr = 1'b0;
    bus.shift_dr   = 1'b0;
    bus.update_dr  = 1'b0;
    bus.tdi        = 1'b0;
    model_reset();
    tick();
    tick();
    push_all();
    check_all("reset");
    exp_q.push_back(32'd0);
    chk("reset.tdo", 32'(bus.chsel_tdo));
    reset_n = 1'b1;
    tick();

    // CHSEL load, masked SHIFT_EN, then read the mask back LSB first
    chsel_write(4'b0101);
    do_ir("shift_en", 7'h0C);
    bus.ir_latched = OPC_CHSEL;
    exp_q.push_back(32'd1);
    #1 chk("chsel_active", 32'(bus.chsel_active));
    bus.capture_dr = 1'b1;
    tick();
    bus.capture_dr = 1'b0;
    bus.tdi = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'(m_mask[i]));
      chk($sformatf("readback.bit%0d", i), 32'(bus.chsel_tdo));
      bus.shift_dr = 1'b1;
      tick();
      bus.shift_dr = 1'b0;
    end

    chsel_write(4'b0010);
    do_ir("reset_en", 7'h10);
    chsel_write(4'hF);
    do_ir("reset_dis", 7'h11);
    do_ir("clksel", 7'h18);
    chsel_write(4'b1000);
    do_ir("clksel_clr", OPC_CLR);

    // Holding an IR without ir_update must not re-apply it
    chsel_write(4'hF);
    bus.ir_latched = 7'h0E;
    repeat (10) tick();
    push_all();
    check_all("hold");
    do_ir("transmit_en", 7'h0E);
    do_ir("rst_ovrd_en", 7'h48);
    do_ir("weakpu", 7'h12);
    do_ir("weakpdn", 7'h14);
    do_ir("chsel_op", OPC_CHSEL);
    chsel_write(4'h0);
    do_ir("mask0_intest", 7'h16);
    chsel_write(4'b0110);
    do_ir("unknown", 7'h7F);
    do_ir("intest", 7'h16);

    // Reset in the middle of a CHSEL shift
    chsel_write(4'b0011);
    bus.ir_latched = OPC_CHSEL;
    bus.capture_dr = 1'b1;
    tick();
    bus.capture_dr = 1'b0;
    bus.shift_dr   = 1'b1;
    bus.tdi        = 1'b1;
    tick();
    tick();
    reset_n = 1'b0;
    model_reset();
    push_all();
    #1 check_all("mid_reset");
    exp_q.push_back(32'd0);
    chk("mid_reset.tdo", 32'(bus.chsel_tdo));
    bus.shift_dr = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Mask update and ir_update in the same edge; the new mask only governs later instructions
    bus.ir_latched = OPC_CHSEL;
    bus.capture_dr = 1'b1;
    tick();
    bus.capture_dr = 1'b0;
    bus.shift_dr   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.tdi = (i == 1 || i == 2);
      tick();
    end
    bus.shift_dr  = 1'b0;
    bus.update_dr = 1'b1;
    bus.ir_update = 1'b1;
    m_mask = 4'b0110;
    push_all();
    tick();
    bus.update_dr = 1'b0;
    bus.ir_update = 1'b0;
    check_all("same_cycle");
    do_ir("after_new_mask", 7'h0C);

    // An instruction edge that also carries update_dr under a non-CHSEL IR leaves the mask alone
    bus.update_dr = 1'b1;
    do_ir("upd_dr_gated", 7'h0E);
    bus.update_dr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/itrx_aib_phy_bscan_mch.md
Name: itrx_aib_phy_bscan_mch

Overview:
- Multi-channel JTAG private-instruction controller for AIB IO columns; next generation of the single-column bscan decoder.
- Decodes the latched IR once per Update-IR and applies each AIB_* instruction only to the channels enabled in a JTAG-loadable channel-select mask.
- Adds a CHSEL data register, a clearable JTAG_CLKSEL and per-channel jtag_* output buses.
- Sits between the TAP controller and NUM_CH AIB IO channel instances.

Parameters:
- NUM_CH, 4, number of AIB channels (1..32).
- IR_WID, 7, latched IR width (>=7; opcodes zero-extended to IR_WID).
- OPC_CHSEL, 7'b100_1010, selects CHSEL DR between TDI and chsel_tdo.
- OPC_CLKSEL_CLR, 7'b001_1001, clears jtag_clksel on selected channels.

Ports:
- tck  input  1  JTAG clock; all state on posedge.
- reset_n  input  1  reset, asynchronous, active-low.
- ir_latched  input  IR_WID  current instruction from TAP.
- ir_update  input  1  one-tck pulse in Update-IR.
- capture_dr  input  1  TAP Capture-DR state.
- shift_dr  input  1  TAP Shift-DR state.
- update_dr  input  1  one-tck pulse in Update-DR.
- tdi  input  1  serial data in.
- chsel_tdo  output  1  CHSEL DR serial out.
- chsel_active  output  1  high when ir_latched==OPC_CHSEL (TDO mux select).
- ch_mask  output  NUM_CH  current channel-select mask.
- jtag_scan_en, jtag_rstn_en, jtag_rstn, jtag_mode, jtag_clksel, jtag_weakpu, jtag_weakpdn, jtag_intest  output  NUM_CH each  per-channel AIB controls.

Behaviour:
- Reset (async): ch_mask all ones; CHSEL shift reg zero; jtag_rstn all ones; every other jtag_* bus zero.
- Opcodes (zero-extended): SHIFT_EN 0x0C, SHIFT_DIS 0x0D, TRANSMIT_EN 0x0E, TRANSMIT_DIS 0x0F, RESET_EN 0x10, RESET_DIS 0x11, WEAKPU_EN 0x12, WEAKPU_DIS 0x13, WEAKPDN_EN 0x14, WEAKPDN_DIS 0x15, INTEST_EN 0x16, INTEST_DIS 0x17, JTAG_CLKSEL 0x18, RESET_OVRD_EN 0x48, RESET_OVRD_DIS 0x49, plus OPC_CLKSEL_CLR and OPC_CHSEL.
- Instruction application:
  - Only on a tck edge with ir_update=1; holding an IR without a new ir_update causes no further change.
  - For each channel i with ch_mask[i]=1, on the edge sampling ir_update:
    - SHIFT_EN/DIS sets/clears scan_en[i].
    - TRANSMIT_EN/DIS sets/clears mode[i].
    - RESET_OVRD_EN/DIS sets/clears rstn_en[i].
    - RESET_EN clears rstn[i]; RESET_DIS sets rstn[i] (rstn is active-low).
    - WEAKPU/WEAKPDN/INTEST _EN/_DIS set/clear their bit.
    - JTAG_CLKSEL sets clksel[i]; OPC_CLKSEL_CLR clears clksel[i].
  - Channels with ch_mask[i]=0 hold all state.
  - Mask all zero: instructions have no effect.
  - Unknown opcode or OPC_CHSEL on ir_update: no jtag_* change.
  - Outputs update on the tck edge sampling ir_update (1-cycle latency), registered.
  - jtag_weakpu and jtag_weakpdn are independent; setting both is permitted and not interlocked.
- CHSEL data register (only when ir_latched==OPC_CHSEL; otherwise shift reg and mask hold):
  - capture_dr: shift reg <= ch_mask.
  - shift_dr: shift reg <= {tdi, shift_reg[NUM_CH-1:1]}; LSB first out.
  - update_dr: ch_mask <= shift reg.
  - capture_dr has priority over shift_dr if both high.
  - chsel_tdo = shift_reg[0], combinational from the flop.
  - chsel_active combinational decode.
- Simultaneous events:
  - ir_update and update_dr in the same cycle: mask updates and the instruction applies using the OLD mask.
  - A new mask affects only subsequent ir_update pulses; it never retro-applies or clears existing channel state.
- Reset mid-operation: partial CHSEL shift discarded; all state to reset values immediately.

Test Plan:
- NUM_CH=4, post-reset -> ch_mask=4'hF, jtag_rstn=4'hF, all other buses 4'h0.
- CHSEL: shift 4'b0101 (LSB first), update_dr, then IR=0x0C with ir_update -> scan_en=4'b0101; capture again reads 0101 on chsel_tdo LSB first.
- Mask=4'b0010, IR=0x10 ir_update -> rstn=4'b1101. Mask=4'hF, IR=0x11 ir_update -> rstn=4'hF.
- IR=0x18 ir_update with mask 4'hF -> clksel=4'hF. Mask=4'b1000, IR=OPC_CLKSEL_CLR -> clksel=4'b0111.
- Hold IR=0x0E for 10 cycles with no ir_update -> mode unchanged. Mask=0, IR=0x16 ir_update -> intest unchanged. Opcode 0x7F -> no change.
- Assert reset_n low mid-CHSEL shift (2 of 4 bits) -> mask 4'hF and shift reg 0 immediately; same-cycle ir_update+update_dr uses the old mask.
